lc3_memory_system: RTL and testbench

Memory and memory-mapped I/O subsystem sitting directly downstream of the LC-3 processor core. It answers the core's single-port bus (`address`, `writeEnable`, `dataToMemory`, `dataFromMemory`) with a word-addressed RAM plus keyboard and display device registers at the standard LC-3 I/O addresses. It also provides a loader port so benches can preload programs without going through the core.

---
 rtl/lc3_memory_system_if.sv | 34 +++
 rtl/lc3_memory_system.sv | 127 ++++++++++++
 tb/tb_lc3_memory_system.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_memory_system_if.sv
// Core/loader/keyboard/display bus between the LC-3 core side and lc3_memory_system.
// Read data is combinational from address; keyboard and display use valid/ready.
interface lc3_mem_if #(
  parameter int ADDR_W = 12
);
  logic              writeEnable;
  logic [15:0]       address;
  logic [15:0]       dataToMemory;
  logic [15:0]       dataFromMemory;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       load_data;
  logic              kbd_valid;
  logic [7:0]        kbd_data;
  logic              kbd_ready;
  logic              disp_valid;
  logic [7:0]        disp_data;
  logic              disp_ready;
  logic              disp_overflow;

  modport master (
    output writeEnable, address, dataToMemory,
    output load_en, load_addr, load_data,
    output kbd_valid, kbd_data, disp_ready,
    input  dataFromMemory, kbd_ready, disp_valid, disp_data, disp_overflow
  );

  modport slave (
    input  writeEnable, address, dataToMemory,
    input  load_en, load_addr, load_data,
    input  kbd_valid, kbd_data, disp_ready,
    output dataFromMemory, kbd_ready, disp_valid, disp_data, disp_overflow
  );
endinterface

// File: rtl/lc3_memory_system.sv
// LC-3 RAM plus KBSR/KBDR/DSR/DDR devices; 0-cycle combinational reads, writes on the edge.
// Keyboard stalls via kbd_ready while KBDR is full; DDR writes into a full display FIFO are dropped.
module lc3_memory_system #(
  parameter int ADDR_W     = 12,
  parameter int DISP_DEPTH = 4
) (
  input logic     clk,
  input logic     reset,
  lc3_mem_if.slave bus
);
  localparam int          PW       = $clog2(DISP_DEPTH);
  localparam logic [15:0] KBSR     = 16'hFE00;
  localparam logic [15:0] KBDR     = 16'hFE02;
  localparam logic [15:0] DSR      = 16'hFE04;
  localparam logic [15:0] DDR      = 16'hFE06;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DISP_DEPTH);

  logic [15:0]   r_ram [2**ADDR_W];

  logic          r_kbd_full;
  logic [7:0]    r_kbd_reg;
  logic [15:0]   r_prev_addr;

  logic [7:0]    r_fifo [DISP_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          r_overflow;

  logic              w_in_ram;
  logic [ADDR_W-1:0] w_ram_idx;
  logic              w_kbd_accept;
  logic              w_kbd_depart;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_ddr_wr;
  logic              w_push;
  logic              w_pop;
  logic [15:0]       w_rdata;

  assign w_in_ram  = (bus.address >> ADDR_W) == 16'h0000;
  assign w_ram_idx = bus.address[ADDR_W-1:0];

  // Loader has priority: any core write on a loader edge is dropped, even to another address.
  always_ff @(posedge clk) begin
    if (bus.load_en) begin
      r_ram[bus.load_addr] <= bus.load_data;
    end else if (bus.writeEnable && w_in_ram) begin
      r_ram[w_ram_idx] <= bus.dataToMemory;
    end
  end

  always_comb begin
    w_rdata = 16'h0000;
    if (w_in_ram) begin
      w_rdata = r_ram[w_ram_idx];
    end else begin
      case (bus.address)
        KBSR:    w_rdata = {r_kbd_full, 15'h0000};
        KBDR:    w_rdata = {8'h00, r_kbd_reg};
        DSR:     w_rdata = {~w_fifo_full, 15'h0000};
        default: w_rdata = 16'h0000;
      endcase
    end
  end

  // The core parks on KBDR for several states, so the read is consumed when it moves away.
  assign w_kbd_accept = bus.kbd_valid & ~r_kbd_full;
  assign w_kbd_depart = (r_prev_addr == KBDR) && (bus.address != KBDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kbd_full  <= 1'b0;
      r_kbd_reg   <= 8'h00;
      r_prev_addr <= 16'h0000;
    end else begin
      r_prev_addr <= bus.address;
      if (w_kbd_accept) begin
        r_kbd_full <= 1'b1;
        r_kbd_reg  <= bus.kbd_data;
      end else if (w_kbd_depart) begin
        r_kbd_full <= 1'b0;
      end
    end
  end

  assign w_fifo_full  = (r_count == FULL_CNT);
  assign w_fifo_empty = (r_count == '0);
  assign w_ddr_wr     = bus.writeEnable && (bus.address == DDR);
  assign w_push       = w_ddr_wr & ~w_fifo_full;
  assign w_pop        = ~w_fifo_empty & bus.disp_ready;

  // Full is judged before the edge, so a same-edge pop never rescues a push into a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DISP_DEPTH; i++) begin
        r_fifo[i] <= 8'h00;
      end
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.dataToMemory[7:0];
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_ddr_wr && w_fifo_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.dataFromMemory = w_rdata;
  assign bus.kbd_ready      = ~r_kbd_full;
  assign bus.disp_valid     = ~w_fifo_empty;
  assign bus.disp_data      = r_fifo[r_rd_ptr];
  assign bus.disp_overflow  = r_overflow;
endmodule

// File: tb/tb_lc3_memory_system.sv
// Directed bench for lc3_memory_system: stimulus queues expectations, a negedge monitor checks them.
module tb_lc3_memory_system;
  localparam int K_RD = 0, K_KRDY = 1, K_DVLD = 2, K_OVF = 3, K_DDAT = 4;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       nm;
  } chk_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  chk_t        chk_q[$];
  logic [7:0]  disp_q[$];
  chk_t        c;
  logic [15:0] act;
  logic [7:0]  e;

  lc3_mem_if #(.ADDR_W(12)) dut_if ();

  lc3_memory_system #(.ADDR_W(12), .DISP_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] actual(int kind);
    case (kind)
      K_RD:    return dut_if.dataFromMemory;
      K_KRDY:  return {15'h0000, dut_if.kbd_ready};
      K_DVLD:  return {15'h0000, dut_if.disp_valid};
      K_OVF:   return {15'h0000, dut_if.disp_overflow};
      K_DDAT:  return {8'h00, dut_if.disp_data};
      default: return 16'hxxxx;
    endcase
  endfunction

  // Scoreboard monitor: checks queued expectations and every display handshake.
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      c   = chk_q.pop_front();
      act = actual(c.kind);
      n_vec++;
      if (act !== c.exp) begin
        n_err++;
        $display("FAIL %s: got %h want %h", c.nm, act, c.exp);
      end
    end
    if (dut_if.disp_valid && dut_if.disp_ready) begin
      n_vec++;
      if (disp_q.size() == 0) begin
        n_err++;
        $display("FAIL disp_extra: got %h want nothing", dut_if.disp_data);
      end else begin
        e = disp_q.pop_front();
        if (dut_if.disp_data !== e) begin
          n_err++;
          $display("FAIL disp_order: got %h want %h", dut_if.disp_data, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_chk(input int kind, input logic [15:0] v, input string nm);
    chk_t t;
    t.kind = kind;
    t.exp  = v;
    t.nm   = nm;
    chk_q.push_back(t);
  endtask

  task automatic core_wr(input logic [15:0] a, input logic [15:0] d);
    dut_if.address      = a;
    dut_if.dataToMemory = d;
    dut_if.writeEnable  = 1'b1;
    cyc();
    dut_if.writeEnable  = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] v, input string nm);
    dut_if.address = a;
    expect_chk(K_RD, v, nm);
    cyc();
  endtask

  task automatic load(input logic [11:0] a, input logic [15:0] d);
    dut_if.load_en   = 1'b1;
    dut_if.load_addr = a;
    dut_if.load_data = d;
    cyc();
    dut_if.load_en   = 1'b0;
  endtask

  task automatic drain(input string nm);
    dut_if.writeEnable = 1'b0;
    dut_if.disp_ready  = 1'b1;
    for (int k = 0; k < 12 && dut_if.disp_valid; k++) cyc();
    expect_chk(K_DVLD, 16'h0000, nm);
    cyc();
  endtask

  logic [7:0] wrap_dat [10];
  logic       wrap_rdy [10];

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    dut_if.writeEnable  = 1'b0;
    dut_if.address      = 16'hFFFF;
    dut_if.dataToMemory = 16'h0000;
    dut_if.load_en      = 1'b0;
    dut_if.load_addr    = '0;
    dut_if.load_data    = 16'h0000;
    dut_if.kbd_valid    = 1'b0;
    dut_if.kbd_data     = 8'h00;
    dut_if.disp_ready   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wrap_dat[i] = 8'h30 + 8'(i);
      wrap_rdy[i] = (i != 0 && i != 1 && i != 4);
    end

    // Reset state
    cyc();
    cyc();
    expect_chk(K_KRDY, 16'h0001, "rst_kbd_ready");
    expect_chk(K_DVLD, 16'h0000, "rst_disp_valid");
    expect_chk(K_OVF,  16'h0000, "rst_overflow");
    expect_chk(K_DDAT, 16'h0000, "rst_disp_data");
    expect_chk(K_RD,   16'h0000, "rst_unmapped_read");
    cyc();
    reset = 1'b0;
    rd(16'hFE04, 16'h8000, "dsr_empty");
    rd(16'hFE00, 16'h0000, "kbsr_empty");

    // Loader then core read; out-of-range addresses
    load(12'h010, 16'h1234);
    rd(16'h0010, 16'h1234, "load_read");
    rd(16'h3000, 16'h0000, "oob_read");
    load(12'h000, 16'h0ABC);
    core_wr(16'h3000, 16'h7777);
    rd(16'h0000, 16'h0ABC, "oob_write_ignored");
    rd(16'hFE06, 16'h0000, "ddr_reads_zero");

    // Core store and loader priority
    core_wr(16'h0005, 16'hBEEF);
    rd(16'h0005, 16'hBEEF, "core_store");
    dut_if.load_en = 1'b1; dut_if.load_addr = 12'h005; dut_if.load_data = 16'h0001;
    core_wr(16'h0005, 16'h5555);
    dut_if.load_en = 1'b0;
    rd(16'h0005, 16'h0001, "loader_wins_same_addr");
    core_wr(16'h0006, 16'h0606);
    dut_if.load_en = 1'b1; dut_if.load_addr = 12'h020; dut_if.load_data = 16'h2222;
    core_wr(16'h0006, 16'h6666);
    dut_if.load_en = 1'b0;
    rd(16'h0006, 16'h0606, "core_dropped_other_addr");
    rd(16'h0020, 16'h2222, "loader_other_addr");
    core_wr(16'h0005, 16'hBEEF);
    rd(16'h0005, 16'hBEEF, "core_restore");

    // Keyboard handshake and departure clear
    dut_if.address = 16'hFE00; dut_if.kbd_valid = 1'b1; dut_if.kbd_data = 8'h41;
    expect_chk(K_KRDY, 16'h0001, "kbd_ready_before");
    cyc();
    dut_if.kbd_valid = 1'b0;
    expect_chk(K_KRDY, 16'h0000, "kbd_ready_after");
    rd(16'hFE00, 16'h8000, "kbsr_full");
    rd(16'hFE02, 16'h0041, "kbdr_data");
    rd(16'hFE02, 16'h0041, "kbdr_hold");
    rd(16'hFE00, 16'h8000, "kbsr_depart_cycle");
    expect_chk(K_KRDY, 16'h0001, "kbd_ready_cleared");
    rd(16'hFE00, 16'h0000, "kbsr_cleared");
    rd(16'hFE02, 16'h0041, "kbdr_retains");
    // Departure and new capture on the same edge: capture wins
    dut_if.address = 16'hFE00; dut_if.kbd_valid = 1'b1; dut_if.kbd_data = 8'h43;
    cyc();
    dut_if.kbd_valid = 1'b0;
    expect_chk(K_KRDY, 16'h0000, "kbd_capture_wins");
    rd(16'hFE00, 16'h8000, "kbsr_capture_wins");
    rd(16'hFE02, 16'h0043, "kbdr_new_data");
    rd(16'h0000, 16'h0ABC, "kbd_leave");

    // Display wrap: 10 pushes with interleaved pops
    for (int i = 0; i < 10; i++) begin
      dut_if.disp_ready = wrap_rdy[i];
      disp_q.push_back(wrap_dat[i]);
      core_wr(16'hFE06, {8'h00, wrap_dat[i]});
    end
    drain("wrap_drained");
    expect_chk(K_OVF, 16'h0000, "wrap_no_overflow");
    cyc();

    // Display fill, overflow, drain
    dut_if.disp_ready = 1'b0;
    core_wr(16'hFE06, 16'h0061);
    expect_chk(K_DVLD, 16'h0001, "first_push_valid");
    expect_chk(K_DDAT, 16'h0061, "first_push_data");
    core_wr(16'hFE06, 16'h0062);
    core_wr(16'hFE06, 16'h0063);
    rd(16'hFE04, 16'h8000, "dsr_three");
    core_wr(16'hFE06, 16'h0064);
    expect_chk(K_OVF, 16'h0000, "full_no_overflow");
    rd(16'hFE04, 16'h0000, "dsr_full");
    core_wr(16'hFE06, 16'h0065);
    expect_chk(K_OVF, 16'h0001, "overflow_set");
    expect_chk(K_DDAT, 16'h0061, "head_after_overflow");
    rd(16'hFE04, 16'h0000, "dsr_still_full");
    disp_q.push_back(8'h61); disp_q.push_back(8'h62);
    disp_q.push_back(8'h63); disp_q.push_back(8'h64);
    dut_if.disp_ready = 1'b1;
    core_wr(16'hFE06, 16'h0066);
    drain("fill_drained");
    expect_chk(K_OVF, 16'h0001, "overflow_sticky");
    cyc();

    // Asynchronous reset with 2 FIFO entries and a pending keyboard character
    dut_if.disp_ready = 1'b0;
    dut_if.kbd_valid = 1'b1; dut_if.kbd_data = 8'h55;
    core_wr(16'hFE06, 16'h0078);
    dut_if.kbd_valid = 1'b0;
    core_wr(16'hFE06, 16'h0079);
    dut_if.address = 16'h0005;
    expect_chk(K_KRDY, 16'h0000, "pre_rst_kbd_ready");
    expect_chk(K_DVLD, 16'h0001, "pre_rst_disp_valid");
    cyc();
    #2;
    reset = 1'b1;
    expect_chk(K_DVLD, 16'h0000, "arst_disp_valid");
    expect_chk(K_KRDY, 16'h0001, "arst_kbd_ready");
    expect_chk(K_OVF,  16'h0000, "arst_overflow");
    expect_chk(K_DDAT, 16'h0000, "arst_disp_data");
    expect_chk(K_RD,   16'hBEEF, "arst_ram_kept");
    cyc();
    reset = 1'b0;
    cyc();
    @(negedge clk);
    #1;

    n_vec++;
    if (disp_q.size() != 0) begin
      n_err++;
      $display("FAIL disp_leftover: got %0d entries pending want 0", disp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
